// File: rtl/store_back_responder.sv
// Store-back target: 16-entry register file plus 256-word data memory with a fixed-latency load path.
// Optional macro READ_BYPASS_EN forwards a writeback to the operand read ports in the same cycle.
module store_back_responder #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int REG_AW   = 4,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              powerdown,
   input  logic              storeNow,
   input  logic [REG_AW-1:0] destRegStore,
   input  logic [DATA_W-1:0] destVal,
   output logic              storeDone,
   input  logic [REG_AW-1:0] rdAddr1,
   input  logic [REG_AW-1:0] rdAddr2,
   output logic [DATA_W-1:0] rdVal1,
   output logic [DATA_W-1:0] rdVal2,
   input  logic              readReq,
   input  logic              writeReq,
   input  logic [ADDR_W-1:0] memAddrLoadStore,
   input  logic [DATA_W-1:0] memValueStore,
   output logic [DATA_W-1:0] memValueLoad,
   output logic              valueReady,
   output logic              busy
);
   localparam int NREG  = 2**REG_AW;
   localparam int DEPTH = 2**ADDR_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] mem_q  [DEPTH];

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] laddr_q, laddr_d;
   logic [DATA_W-1:0] load_q, load_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q;

   logic wb_fire;
   logic st_fire;

   // storeDone high blocks a held storeNow from writing twice
   assign wb_fire = storeNow & ~done_q & ~powerdown;
   assign st_fire = writeReq & ~powerdown;

   always_comb begin
      rdVal1 = regs_q[rdAddr1];
      rdVal2 = regs_q[rdAddr2];
`ifdef READ_BYPASS_EN
      if (wb_fire && destRegStore == rdAddr1) rdVal1 = destVal;
      if (wb_fire && destRegStore == rdAddr2) rdVal2 = destVal;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      laddr_d = laddr_q;
      load_d  = load_q;
      ready_d = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (readReq && !powerdown) begin
               laddr_d = memAddrLoadStore;
               cnt_d   = LAT_M1;
               busy_d  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // sampled late so stores during the wait are returned
               load_d  = mem_q[laddr_q];
               ready_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         laddr_q <= '0;
         load_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         laddr_q <= laddr_d;
         load_q  <= load_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= wb_fire;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wb_fire) begin
         regs_q[destRegStore] <= destVal;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (st_fire) begin
         mem_q[memAddrLoadStore] <= memValueStore;
      end
   end

   assign storeDone    = done_q;
   assign memValueLoad = load_q;
   assign valueReady   = ready_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_store_back_responder.sv
// Bench for store_back_responder: vector table, directed corner sequences, random traffic vs a model.
// Expected operand values honour READ_BYPASS_EN when the bench is built with it.
module tb_store_back_responder;
   localparam int READ_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        powerdown;
   logic        storeNow;
   logic [3:0]  destRegStore;
   logic [15:0] destVal;
   logic        storeDone;
   logic [3:0]  rdAddr1;
   logic [3:0]  rdAddr2;
   logic [15:0] rdVal1;
   logic [15:0] rdVal2;
   logic        readReq;
   logic        writeReq;
   logic [7:0]  memAddrLoadStore;
   logic [15:0] memValueStore;
   logic [15:0] memValueLoad;
   logic        valueReady;
   logic        busy;

   always #5 clk = ~clk;

   store_back_responder #(
      .ADDR_W(8), .DATA_W(16), .REG_AW(4), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .rst(rst), .powerdown(powerdown),
      .storeNow(storeNow), .destRegStore(destRegStore),
      .destVal(destVal), .storeDone(storeDone),
      .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
      .rdVal1(rdVal1), .rdVal2(rdVal2),
      .readReq(readReq), .writeReq(writeReq),
      .memAddrLoadStore(memAddrLoadStore),
      .memValueStore(memValueStore),
      .memValueLoad(memValueLoad),
      .valueReady(valueReady), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  name, $time, act, exp);
      end
   endtask

   // Behavioural model: arrays plus the edge index at which the load was accepted
   logic [15:0] mreg [16];
   logic [15:0] mmem [256];
   bit          m_valid = 0;
   bit          m_sd, m_vr, m_busy;
   logic [15:0] m_load;
   bit          l_act;
   int          l_acc;
   logic [7:0]  l_addr;
   int          e = 0;

   function automatic logic [15:0] exp_rd(input logic [3:0] a);
      logic [15:0] v;
      v = mreg[a];
`ifdef READ_BYPASS_EN
      if (storeNow && !m_sd && !powerdown && destRegStore == a) v = destVal;
`endif
      return v;
   endfunction

   task automatic model_edge();
      bit wb;
      if (!rst) begin
         for (int i = 0; i < 16; i++) mreg[i] = '0;
         for (int i = 0; i < 256; i++) mmem[i] = '0;
         m_sd = 0; m_vr = 0; m_busy = 0; m_load = '0;
         l_act = 0; l_acc = 0; l_addr = '0;
         m_valid = 1;
      end else if (m_valid) begin
         wb   = storeNow && !m_sd && !powerdown;
         m_vr = l_act && (e == l_acc + READ_LAT);
         if (m_vr) m_load = mmem[l_addr];
         if (readReq && !powerdown &&
             (!l_act || e >= l_acc + READ_LAT + 2)) begin
            l_act  = 1;
            l_acc  = e;
            l_addr = memAddrLoadStore;
         end
         m_busy = l_act && (e <= l_acc + READ_LAT);
         if (writeReq && !powerdown) mmem[memAddrLoadStore] = memValueStore;
         if (wb) mreg[destRegStore] = destVal;
         m_sd = wb;
      end
      e++;
   endtask

   task automatic step();
      #1;
      if (m_valid) begin
         chk("rdVal1", 32'(rdVal1), 32'(exp_rd(rdAddr1)));
         chk("rdVal2", 32'(rdVal2), 32'(exp_rd(rdAddr2)));
      end
      @(posedge clk);
      model_edge();
      #1;
      if (m_valid) begin
         chk("storeDone", 32'(storeDone), 32'(m_sd));
         chk("valueReady", 32'(valueReady), 32'(m_vr));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("memValueLoad", 32'(memValueLoad), 32'(m_load));
      end
   endtask

   task automatic idle();
      rst = 1'b1; powerdown = 1'b0;
      storeNow = 1'b0; destRegStore = '0; destVal = '0;
      rdAddr1 = '0; rdAddr2 = '0;
      readReq = 1'b0; writeReq = 1'b0;
      memAddrLoadStore = '0; memValueStore = '0;
   endtask

   typedef struct {
      logic        sn;
      logic [3:0]  dr;
      logic [15:0] dv;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic        rq;
      logic        wq;
      logic [7:0]  addr;
      logic [15:0] wv;
      logic        sd;
      logic        vr;
      logic        bz;
      logic [15:0] ld;
      logic [15:0] rd1;
      logic [15:0] rd2;
   } vec_t;

   vec_t tv [8];
   int   pulses;

   initial begin
      tv[0] = '{1'b1, 4'd12, 16'd54, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 16'd0,
                1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0};
      tv[1] = '{1'b1, 4'd12, 16'd99, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 16'd0,
                1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0};
      tv[2] = '{1'b0, 4'd0, 16'd0, 4'd12, 4'd12, 1'b0, 1'b1, 8'd180, 16'd45,
                1'b0, 1'b0, 1'b0, 16'd0, 16'd54, 16'd54};
      tv[3] = '{1'b0, 4'd0, 16'd0, 4'd12, 4'd12, 1'b1, 1'b0, 8'd180, 16'd0,
                1'b0, 1'b0, 1'b1, 16'd0, 16'd54, 16'd54};
      tv[4] = '{1'b0, 4'd0, 16'd0, 4'd12, 4'd12, 1'b1, 1'b0, 8'd180, 16'd0,
                1'b0, 1'b0, 1'b1, 16'd0, 16'd54, 16'd54};
      tv[5] = '{1'b0, 4'd0, 16'd0, 4'd12, 4'd12, 1'b1, 1'b0, 8'd180, 16'd0,
                1'b0, 1'b1, 1'b1, 16'd45, 16'd54, 16'd54};
      tv[6] = '{1'b0, 4'd0, 16'd0, 4'd12, 4'd12, 1'b0, 1'b0, 8'd0, 16'd0,
                1'b0, 1'b0, 1'b0, 16'd45, 16'd54, 16'd54};
      tv[7] = '{1'b0, 4'd0, 16'd0, 4'd12, 4'd12, 1'b0, 1'b0, 8'd0, 16'd0,
                1'b0, 1'b0, 1'b0, 16'd45, 16'd54, 16'd54};

      idle();
      rst = 1'b0;
      step();
      step();
      chk("reset_storeDone", 32'(storeDone), 32'd0);
      chk("reset_valueReady", 32'(valueReady), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_load", 32'(memValueLoad), 32'd0);

      // writeback handshake, store then fixed-latency load
      idle();
      for (int i = 0; i < 8; i++) begin
         storeNow = tv[i].sn; destRegStore = tv[i].dr; destVal = tv[i].dv;
         rdAddr1 = tv[i].ra1; rdAddr2 = tv[i].ra2;
         readReq = tv[i].rq; writeReq = tv[i].wq;
         memAddrLoadStore = tv[i].addr; memValueStore = tv[i].wv;
         step();
         chk($sformatf("tv%0d_storeDone", i), 32'(storeDone), 32'(tv[i].sd));
         chk($sformatf("tv%0d_valueReady", i), 32'(valueReady), 32'(tv[i].vr));
         chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].bz));
         chk($sformatf("tv%0d_load", i), 32'(memValueLoad), 32'(tv[i].ld));
         chk($sformatf("tv%0d_rdVal1", i), 32'(rdVal1), 32'(tv[i].rd1));
         chk($sformatf("tv%0d_rdVal2", i), 32'(rdVal2), 32'(tv[i].rd2));
      end

      // reset after stores clears registers and memory
      idle();
      rst = 1'b0;
      step();
      step();
      chk("rst2_load", 32'(memValueLoad), 32'd0);
      chk("rst2_busy", 32'(busy), 32'd0);
      idle();
      rdAddr1 = 4'd12;
      step();
      chk("rst2_reg12", 32'(rdVal1), 32'd0);
      readReq = 1'b1; memAddrLoadStore = 8'd180;
      step();
      step();
      step();
      chk("rst2_vr", 32'(valueReady), 32'd1);
      chk("rst2_mem180", 32'(memValueLoad), 32'd0);
      readReq = 1'b0;
      step();

      // store to pending address during WAIT, re-requests ignored
      idle();
      readReq = 1'b1; memAddrLoadStore = 8'd7;
      step();
      chk("raw_busy", 32'(busy), 32'd1);
      writeReq = 1'b1; memValueStore = 16'hBEEF;
      step();
      pulses = int'(valueReady);
      writeReq = 1'b0; memAddrLoadStore = 8'd180;
      step();
      pulses += int'(valueReady);
      chk("raw_data", 32'(memValueLoad), 32'hBEEF);
      readReq = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(valueReady);
      end
      chk("raw_pulses", 32'(pulses), 32'd1);
      chk("raw_busy_end", 32'(busy), 32'd0);

      // powerdown blocks new requests
      idle();
      powerdown = 1'b1;
      storeNow = 1'b1; destRegStore = 4'd3; destVal = 16'd77;
      writeReq = 1'b1; memAddrLoadStore = 8'd20; memValueStore = 16'h1234;
      readReq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pd_storeDone", 32'(storeDone), 32'd0);
         chk("pd_busy", 32'(busy), 32'd0);
      end
      idle();
      rdAddr1 = 4'd3; readReq = 1'b1; memAddrLoadStore = 8'd20;
      step();
      step();
      step();
      chk("pd_mem20", 32'(memValueLoad), 32'd0);
      chk("pd_reg3", 32'(rdVal1), 32'd0);
      readReq = 1'b0;
      step();
      readReq = 1'b1; memAddrLoadStore = 8'd7;
      step();
      powerdown = 1'b1;
      step();
      step();
      chk("pd_inflight_vr", 32'(valueReady), 32'd1);
      chk("pd_inflight_data", 32'(memValueLoad), 32'hBEEF);
      idle();
      step();

      // reset during WAIT aborts the load
      idle();
      readReq = 1'b1; memAddrLoadStore = 8'd7;
      step();
      readReq = 1'b0; rst = 1'b0;
      step();
      chk("abort_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         pulses += int'(valueReady);
      end
      chk("abort_pulses", 32'(pulses), 32'd0);

      // same-cycle forwarding of a writeback
      storeNow = 1'b1; destRegStore = 4'd2; destVal = 16'd29; rdAddr1 = 4'd2;
      #1;
`ifdef READ_BYPASS_EN
      chk("bypass_same_cycle", 32'(rdVal1), 32'd29);
`else
      chk("bypass_same_cycle", 32'(rdVal1), 32'd0);
`endif
      step();
      chk("bypass_after_edge", 32'(rdVal1), 32'd29);
      storeNow = 1'b0;
      step();

      // random traffic on a small address window to force collisions
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(63) != 0);
         powerdown = ($urandom_range(7) == 0);
         storeNow = ($urandom_range(2) == 0);
         destRegStore = 4'($urandom_range(15));
         destVal = 16'($urandom);
         rdAddr1 = 4'($urandom_range(15));
         rdAddr2 = ($urandom_range(1) == 0) ? destRegStore : 4'($urandom_range(15));
         readReq = 1'($urandom_range(1));
         writeReq = ($urandom_range(2) == 0);
         memAddrLoadStore = 8'($urandom_range(7));
         memValueStore = 16'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
